// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte-stream requesters share one
//   UART transmitter. A grant is held for a whole packet. A packet ends on
//   the requester's last byte, or after MAX_PKT_BYTES bytes, or when the
//   transmitter fails to report busy within BUSY_TIMEOUT cycles.
//
// Ports
//   i_clk, i_rst_n  clock (rising edge); asynchronous active-low reset
//   i_req_valid     per-requester byte valid
//   i_req_data      per-requester byte; requester k on [8k+7:8k]
//   i_req_last      per-requester end-of-packet marker
//   o_req_ready     per-requester accept (only the granted bit can be set)
//   o_tx_en         one-cycle launch strobe to the UART
//   o_tx_data       byte for the UART, valid while o_tx_en is high
//   i_tx_busy       UART busy; rises the cycle after an accepted o_tx_en
//   o_grant         one-hot owner, all-zero when idle
//   o_err           one-cycle pulse on busy timeout
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT_BYTES = 16,
    parameter int BUSY_TIMEOUT  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_en,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_busy,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_err
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       MAX_CNT  = 8'(MAX_PKT_BYTES);
    localparam logic [7:0]       TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t             state_q,    state_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [IDX_W-1:0]   gidx_q,     gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic               last_q,     last_d;
    logic [7:0]         tmr_q,      tmr_d;
    logic               err_q,      err_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               do_release;
    int unsigned        j;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_found && i_req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        last_d      = last_q;
        tmr_d       = tmr_q;
        err_d       = 1'b0;
        do_release  = 1'b0;
        o_tx_en     = 1'b0;
        o_req_ready = '0;
        o_tx_data   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found && !i_tx_busy) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_tx_data = i_req_data[int'(gidx_q)*8 +: 8];
                // Busy gating is redundant on entry paths but guarantees no
                // launch can ever overlap a frame in flight.
                if (i_req_valid[gidx_q] && !i_tx_busy) begin
                    o_tx_en             = 1'b1;
                    o_req_ready[gidx_q] = 1'b1;
                    last_d              = i_req_last[gidx_q];
                    byte_cnt_d          = byte_cnt_q + 8'd1;
                    tmr_d               = '0;
                    state_d             = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (i_tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmr_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    do_release = 1'b1;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_WAIT_LO: begin
                if (!i_tx_busy) begin
                    if (last_q || byte_cnt_q == MAX_CNT) do_release = 1'b1;
                    else                                 state_d    = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Common release path for end-of-packet, byte limit and timeout.
        if (do_release) begin
            grant_d    = '0;
            byte_cnt_d = '0;
            rr_ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
            state_d    = S_IDLE;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
            tmr_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
        end
    end

    assign o_grant = grant_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Two instances share the stimulus:
// u_dut uses default parameters, u_dut_m2 uses MAX_PKT_BYTES=2 for the
// forced-release scenario; sel chooses which one the harness observes.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 6;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic           tx_busy   = 1'b0;
    logic           sel       = 1'b0;
    logic           uart_en   = 1'b1;

    logic [N-1:0] ready_a, ready_b, grant_a, grant_b;
    logic         tx_en_a, tx_en_b, err_a, err_b;
    logic [7:0]   tx_data_a, tx_data_b;

    logic [N-1:0] req_ready, grant;
    logic         tx_en, err;
    logic [7:0]   tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(ready_a), .o_tx_en(tx_en_a), .o_tx_data(tx_data_a),
        .i_tx_busy(tx_busy), .o_grant(grant_a), .o_err(err_a)
    );

    uart_tx_arbiter #(.MAX_PKT_BYTES(2)) u_dut_m2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(ready_b), .o_tx_en(tx_en_b), .o_tx_data(tx_data_b),
        .i_tx_busy(tx_busy), .o_grant(grant_b), .o_err(err_b)
    );

    assign req_ready = sel ? ready_b   : ready_a;
    assign grant     = sel ? grant_b   : grant_a;
    assign tx_en     = sel ? tx_en_b   : tx_en_a;
    assign err       = sel ? err_b     : err_a;
    assign tx_data   = sel ? tx_data_b : tx_data_a;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Per-requester byte sources: {last, data}
    logic [8:0] src_mem [N][32];
    int         src_head [N];
    int         src_tail [N];

    task automatic load(input int k, input logic [7:0] d, input logic l);
        src_mem[k][src_tail[k]] = {l, d};
        src_tail[k]++;
    endtask

    task automatic clear_src();
        for (int k = 0; k < N; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (src_head[k] < src_tail[k]) begin
                req_valid[k]                        = 1'b1;
                {req_last[k], req_data[8*k +: 8]}   = src_mem[k][src_head[k]];
            end else begin
                req_valid[k]        = 1'b0;
                req_last[k]         = 1'b0;
                req_data[8*k +: 8]  = 8'h00;
            end
        end
    endtask

    // Handshake log
    int           obs_req  [64];
    logic [7:0]   obs_data [64];
    logic [N-1:0] obs_grant[64];
    int unsigned  obs_cyc  [64];
    int           obs_n = 0;

    initial begin : driver
        bit hs;
        int gi;
        clear_src();
        forever begin
            @(negedge clk);
            hs = tx_en && rst_n;
            gi = 0;
            if (hs && obs_n < 64) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
                obs_req[obs_n]   = gi;
                obs_data[obs_n]  = tx_data;
                obs_grant[obs_n] = grant;
            end
            @(posedge clk);
            #1;
            if (hs && obs_n < 64) begin
                obs_cyc[obs_n] = cyc;
                obs_n++;
                if (src_head[gi] < src_tail[gi]) src_head[gi]++;
            end
            refresh();
        end
    end

    // UART model: busy for FRAME cycles starting the cycle after a launch.
    initial begin : uart_model
        forever begin
            @(negedge clk);
            if (uart_en && tx_en && rst_n) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (FRAME) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        clear_src();
        obs_n = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 50 && tx_busy; i++) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_n < n; i++) @(negedge clk);
        if (obs_n < n) check("wait_handshake", obs_n, n);
    endtask

    task automatic expect_seq(input string tag, input int first, input int cnt,
                              input int reqs[8], input logic [7:0] bytes[8]);
        for (int i = 0; i < cnt; i++) begin
            check({tag, "_req"},  obs_req[first+i],  reqs[i]);
            check({tag, "_data"}, obs_data[first+i], bytes[i]);
        end
    endtask

    initial begin : main
        int          reqs [8];
        logic [7:0]  bytes[8];
        bit          found;
        int unsigned err_cyc;

        // Reset values
        #12;
        check("rst_grant", grant,     0);
        check("rst_tx_en", tx_en,     0);
        check("rst_ready", req_ready, 0);
        check("rst_err",   err,       0);
        check("rst_data",  tx_data,   0);

        // Single packet on req0, then rr_ptr must point at req1
        do_reset();
        load(0, 8'h55, 1'b0);
        load(0, 8'hAA, 1'b1);
        wait_obs(2, 100);
        reqs  = '{0, 0, 0, 0, 0, 0, 0, 0};
        bytes = '{8'h55, 8'hAA, 0, 0, 0, 0, 0, 0};
        expect_seq("single", 0, 2, reqs, bytes);
        check("single_grant0", obs_grant[0], 4'b0001);
        check("single_grant1", obs_grant[1], 4'b0001);
        load(0, 8'h11, 1'b1);
        load(1, 8'h22, 1'b1);
        wait_obs(4, 100);
        check("rr_after_single_first", obs_req[2], 1);
        check("rr_after_single_next",  obs_req[3], 0);

        // Round robin across all four
        do_reset();
        load(0, 8'hA0, 1'b1);
        load(1, 8'hA1, 1'b1);
        load(2, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b1);
        load(0, 8'hB0, 1'b1);
        wait_obs(5, 200);
        reqs  = '{0, 1, 2, 3, 0, 0, 0, 0};
        bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 0, 0, 0};
        expect_seq("rr", 0, 5, reqs, bytes);

        // Packet lock: req1 three bytes before req2
        do_reset();
        load(1, 8'hC1, 1'b0);
        load(1, 8'hC2, 1'b0);
        load(1, 8'hC3, 1'b1);
        load(2, 8'hD1, 1'b1);
        wait_obs(4, 200);
        reqs  = '{1, 1, 1, 2, 0, 0, 0, 0};
        bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hD1, 0, 0, 0, 0};
        expect_seq("lock", 0, 4, reqs, bytes);

        // Forced release with MAX_PKT_BYTES=2
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) load(0, 8'hE0 + 8'(i), 1'b0);
        load(3, 8'hF0, 1'b1);
        wait_obs(6, 300);
        reqs  = '{0, 0, 3, 0, 0, 0, 0, 0};
        bytes = '{8'hE0, 8'hE1, 8'hF0, 8'hE2, 8'hE3, 8'hE4, 0, 0};
        expect_seq("maxpkt", 0, 6, reqs, bytes);
        // req0 ran dry mid-packet: grant must be held, nothing launched
        repeat (20) @(negedge clk);
        check("hold_grant", grant, 4'b0001);
        check("hold_tx_en", tx_en, 0);
        sel = 1'b0;

        // Busy timeout
        do_reset();
        uart_en = 1'b0;
        load(2, 8'h3C, 1'b1);
        wait_obs(1, 50);
        found   = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (err) begin
                found   = 1'b1;
                err_cyc = cyc;
            end
        end
        check("tmo_seen",   found, 1);
        check("tmo_cycles", err_cyc - obs_cyc[0], 8);
        check("tmo_grant",  grant, 0);
        @(negedge clk);
        check("tmo_err_once", err,   0);
        check("tmo_idle",     tx_en, 0);
        uart_en = 1'b1;
        // Timeout released req2, so req3 is next in line ahead of req0
        load(0, 8'h10, 1'b1);
        load(3, 8'h13, 1'b1);
        wait_obs(3, 100);
        check("tmo_rr_first", obs_req[1], 3);
        check("tmo_rr_next",  obs_req[2], 0);

        // Reset mid-frame while req2 owns the transmitter
        do_reset();
        load(2, 8'h71, 1'b0);
        load(2, 8'h72, 1'b0);
        wait_obs(1, 50);
        @(posedge clk);
        #2;
        check("mid_grant_before", grant, 4'b0100);
        rst_n = 1'b0;
        load(0, 8'h99, 1'b1);
        #1;
        check("mid_rst_grant", grant,     0);
        check("mid_rst_tx_en", tx_en,     0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_err",   err,       0);
        check("mid_rst_data",  tx_data,   0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_obs(2, 100);
        check("mid_after_req",  obs_req[1],  0);
        check("mid_after_data", obs_data[1], 8'h99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
